flag_ctrl: RTL
==============

Name: flag_ctrl

Overview:
Condition-code controller for the 3-bit ZVN flag register in the CPU core.
- Decodes the EX-stage opcode into per-flag write enables and updates the internal flag register.
- Resolves ID-stage branch conditions against those flags.
- Stalls the branch for one cycle when a flag-writing instruction is still in EX (RAW hazard on flags).
- Keeps a saturating count of flag-hazard stall cycles for performance analysis.

Parameters:
CNT_W, 16, width of stall performance counter
STALL_EN, 1, 1 = stall on flag hazard; 0 = resolve immediately with current flags (no HOLD state)

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  reset; asynchronous, active-high; clears all state
ex_valid  input  1  EX stage holds a valid instruction
ex_opcode  input  4  EX-stage opcode
ex_z  input  1  ALU zero result for EX instruction
ex_v  input  1  ALU overflow result
ex_n  input  1  ALU negative result
br_req  input  1  ID stage holds a conditional branch
br_ccc  input  3  branch condition code
flush  input  1  pipeline flush; cancels any pending branch
cnt_clr  input  1  synchronous clear of stall counter
flags  output  3  current flag register, {Z,V,N}
br_stall  output  1  hold IF/ID this cycle
br_valid  output  1  branch resolved this cycle
br_taken  output  1  resolution result; qualified by br_valid
stall_cnt  output  CNT_W  saturating flag-stall cycle count

Behaviour:
- Reset values: flags=3'b000, state=IDLE, stall_cnt=0. br_stall=0, br_valid=0, br_taken=0 while rst is asserted.
- Flag write enables, active only when ex_valid=1:
  - 0000 ADD, 0001 SUB: write Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only.
  - All other opcodes: no write.
- Unwritten flag bits hold their value. The update occurs at the posedge ending the EX cycle.
- hazard = ex_valid & (any flag write enable).
- Condition codes, evaluated on Z/V/N:
  - 000 NEQ: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | (!Z & !N)
  - 101 LTE: N | Z
  - 110 OVF: V
  - 111 UNCOND: 1
- FSM states: IDLE, HOLD.
- IDLE:
  - br_req=0: all branch outputs 0.
  - br_req=1, hazard=0 (or STALL_EN=0): br_valid=1 combinationally, br_taken = cond(br_ccc, flags), stay in IDLE.
  - br_req=1, hazard=1, STALL_EN=1: br_stall=1, br_valid=0; capture br_ccc into ccc_q; next state HOLD.
- HOLD (flags now include the EX writer's update):
  - br_valid=1, br_taken = cond(ccc_q, flags), br_stall=0; next state IDLE.
  - ex_valid in HOLD still updates flags at the ending edge, but does not affect this resolution and never re-triggers a stall.
- flush:
  - flush=1 in IDLE suppresses br_stall/br_valid that cycle.
  - flush=1 in HOLD forces br_valid=0 and next state IDLE.
  - flush does not block flag writes.
- br_req dropping during HOLD is ignored; resolution uses ccc_q.
- stall_cnt:
  - Increments by 1 on each cycle with br_stall=1.
  - Saturates at all-ones.
  - cnt_clr has priority over increment.
- Reset asserted mid-HOLD: immediately IDLE, outputs 0, no resolution emitted.

Test Plan:
- Reset, then ex_valid=1, ADD, z/v/n=1/0/1 → next cycle flags=3'b101; XOR with z=0 → flags=3'b001 (V and N held).
- flags=3'b100, no hazard, br_req=1, ccc=001 → same cycle br_valid=1, br_taken=1, br_stall=0; ccc=000 → br_taken=0.
- SUB in EX (z=0,v=1,n=0) with br_req=1, ccc=110 → cycle0 br_stall=1, br_valid=0; cycle1 br_valid=1, br_taken=1; stall_cnt=1.
- Hazard stall into HOLD with flush=1 in HOLD → br_valid=0; next cycle state IDLE; flags still updated.
- Force stall_cnt to all-ones via 2^CNT_W stalls (use CNT_W=4: 16 stalls) → holds 4'hF; cnt_clr=1 together with a stall → 0.
- Assert rst asynchronously mid-HOLD → flags=0, br_valid=0 before the next clock edge; deassert → IDLE behaviour.

Source files
------------

// File: rtl/flag_ctrl.sv
// ZVN condition-code controller: EX-stage flag updates, ID-stage branch
// resolution with a one-cycle stall on flag RAW hazards, and a stall counter.
module flag_ctrl #(
  parameter int unsigned CNT_W    = 16,
  parameter bit          STALL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_opcode,
  input  logic             ex_z,
  input  logic             ex_v,
  input  logic             ex_n,
  input  logic             br_req,
  input  logic [2:0]       br_ccc,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [2:0]       flags,
  output logic             br_stall,
  output logic             br_valid,
  output logic             br_taken,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, HOLD} state_e;

  state_e           state_q, state_d;
  logic [2:0]       flags_q, flags_d;
  logic [2:0]       ccc_q, ccc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_all, wr_z_only, we_z, we_vn, hazard;

  // Branch condition evaluated on {Z,V,N}.
  function automatic logic cond_f(input logic [2:0] ccc, input logic [2:0] f);
    logic z, v, n;
    z = f[2];
    v = f[1];
    n = f[0];
    case (ccc)
      3'b000:  cond_f = !z;
      3'b001:  cond_f = z;
      3'b010:  cond_f = !z && !n;
      3'b011:  cond_f = n;
      3'b100:  cond_f = z || (!z && !n);
      3'b101:  cond_f = n || z;
      3'b110:  cond_f = v;
      default: cond_f = 1'b1;
    endcase
  endfunction

  // Opcode decode into per-flag write enables.
  always_comb begin
    wr_all    = 1'b0;
    wr_z_only = 1'b0;
    case (ex_opcode)
      4'b0000, 4'b0001:         wr_all    = 1'b1;
      4'b0010, 4'b0100,
      4'b0101, 4'b0110:         wr_z_only = 1'b1;
      default: ;
    endcase
  end

  assign we_z   = ex_valid && (wr_all || wr_z_only);
  assign we_vn  = ex_valid && wr_all;
  assign hazard = we_z;

  always_comb begin
    flags_d    = flags_q;
    flags_d[2] = we_z  ? ex_z : flags_q[2];
    flags_d[1] = we_vn ? ex_v : flags_q[1];
    flags_d[0] = we_vn ? ex_n : flags_q[0];
  end

  // Branch FSM; outputs are forced low while reset is held.
  always_comb begin
    state_d  = state_q;
    ccc_d    = ccc_q;
    br_stall = 1'b0;
    br_valid = 1'b0;
    br_taken = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_req && !flush) begin
          if (hazard && STALL_EN) begin
            br_stall = 1'b1;
            ccc_d    = br_ccc;
            state_d  = HOLD;
          end else begin
            br_valid = 1'b1;
            br_taken = cond_f(br_ccc, flags_q);
          end
        end
      end
      HOLD: begin
        state_d = IDLE;
        if (!flush) begin
          br_valid = 1'b1;
          br_taken = cond_f(ccc_q, flags_q);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      br_stall = 1'b0;
      br_valid = 1'b0;
      br_taken = 1'b0;
    end
  end

  // Saturating stall counter; clear wins over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (br_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      flags_q <= 3'b000;
      ccc_q   <= 3'b000;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      ccc_q   <= ccc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flags     = flags_q;
  assign stall_cnt = cnt_q;

endmodule
